// File: rtl/multicycle_cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: opcodes, function codes,
// and the select/fault code values driven onto the datapath.
package multicycle_cpu_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FUNC_SYSCALL = 6'h0C;

    localparam logic [1:0] NPC_PC4    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;

    localparam logic [1:0] REG_SRC_ALU = 2'b00;
    localparam logic [1:0] REG_SRC_MEM = 2'b01;
    localparam logic [1:0] REG_SRC_IMM = 2'b10;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_MEM_TMO = 2'b01;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b10;

    // Opcodes that need an EXEC cycle after DECODE.
    function automatic logic needs_exec(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multicycle_cpu_ctrl_timeout.sv
// Memory wait-state watchdog: counts consecutive un-acknowledged request cycles and
// flags the cycle in which one more wait would reach the TIMEOUT limit.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expired
);
    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_count_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Expired means this wait cycle is the TIMEOUT-th one; a ready in the same cycle still wins.
    assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/multicycle_cpu_ctrl.sv
// Control FSM for the multi-cycle MIPS core: sequences fetch/decode/exec/mem/wb over the
// shared datapath, handles memory wait states, syscalls, halt/fault and activity counters.
module multicycle_cpu_ctrl
    import multicycle_cpu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic [5:0]       i_opcode,
    input  logic [5:0]       i_func,
    input  logic             i_zero,
    input  logic             i_mem_ready,
    input  logic             i_sys_ack,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic             o_mem_addr_sel,
    output logic             o_ir_write,
    output logic             o_pc_write,
    output logic [1:0]       o_npc_sel,
    output logic             o_reg_write,
    output logic             o_reg_dst,
    output logic [1:0]       o_reg_src,
    output logic             o_alu_src2,
    output logic [1:0]       o_alu_op,
    output logic             o_syscall,
    output logic             o_halt,
    output logic             o_fault,
    output logic [1:0]       o_fault_code,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [CNT_W-1:0] o_instr_cnt
);
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_SYS, S_HALT, S_FAULT
    } state_t;

    state_t           r_state, w_state_next;
    logic [5:0]       r_opcode, r_func;
    logic [1:0]       r_fault_code, w_fault_code_next;
    logic [CNT_W-1:0] r_cycle_cnt, r_instr_cnt;
    logic             w_retire, w_active;
    logic             w_tmo_clear, w_tmo_count, w_tmo_expired;

    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (w_tmo_clear),
        .i_count_en (w_tmo_count),
        .o_expired  (w_tmo_expired)
    );

    // Every entry into FETCH/MEM comes from a non-request cycle or a ready cycle, so this also clears on entry.
    assign w_tmo_clear = ~o_mem_req | i_mem_ready;
    assign w_tmo_count = o_mem_req & ~i_mem_ready;

    always_comb begin
        w_state_next      = r_state;
        w_fault_code_next = r_fault_code;
        w_retire          = 1'b0;
        o_mem_req         = 1'b0;
        o_mem_we          = 1'b0;
        o_mem_addr_sel    = 1'b0;
        o_ir_write        = 1'b0;
        o_pc_write        = 1'b0;
        o_npc_sel         = NPC_PC4;
        o_reg_write       = 1'b0;
        o_reg_dst         = 1'b0;
        o_reg_src         = REG_SRC_ALU;
        o_alu_src2        = 1'b0;
        o_alu_op          = ALU_ADD;
        o_syscall         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_run) w_state_next = S_FETCH;
            end
            S_FETCH: begin
                o_mem_req = 1'b1;
                if (i_mem_ready) begin
                    o_ir_write   = 1'b1;
                    o_pc_write   = 1'b1;
                    w_state_next = S_DECODE;
                end else if (w_tmo_expired) begin
                    w_state_next      = S_FAULT;
                    w_fault_code_next = FAULT_MEM_TMO;
                end
            end
            S_DECODE: begin
                if (i_opcode == OP_J) begin
                    o_pc_write = 1'b1;
                    o_npc_sel  = NPC_JUMP;
                    w_retire   = 1'b1;
                end else if (i_opcode == OP_HALT) begin
                    w_state_next = S_HALT;
                end else if (needs_exec(i_opcode)) begin
                    w_state_next = S_EXEC;
                end else begin
                    w_state_next      = S_FAULT;
                    w_fault_code_next = FAULT_ILLEGAL;
                end
            end
            S_EXEC: begin
                case (r_opcode)
                    OP_RTYPE: begin
                        o_alu_op     = ALU_FUNC;
                        w_state_next = (r_func == FUNC_SYSCALL) ? S_SYS : S_WB;
                    end
                    OP_LW, OP_SW: begin
                        o_alu_src2   = 1'b1;
                        w_state_next = S_MEM;
                    end
                    OP_ADDI: begin
                        o_alu_src2   = 1'b1;
                        w_state_next = S_WB;
                    end
                    OP_BEQ: begin
                        o_alu_op   = ALU_SUB;
                        o_pc_write = i_zero;
                        o_npc_sel  = NPC_BRANCH;
                        w_retire   = 1'b1;
                    end
                    default: begin
                        w_state_next      = S_FAULT;
                        w_fault_code_next = FAULT_ILLEGAL;
                    end
                endcase
            end
            S_MEM: begin
                o_mem_req      = 1'b1;
                o_mem_addr_sel = 1'b1;
                o_mem_we       = (r_opcode == OP_SW);
                if (i_mem_ready) begin
                    if (r_opcode == OP_SW) w_retire = 1'b1;
                    else                   w_state_next = S_WB;
                end else if (w_tmo_expired) begin
                    w_state_next      = S_FAULT;
                    w_fault_code_next = FAULT_MEM_TMO;
                end
            end
            S_WB: begin
                o_reg_write = 1'b1;
                o_reg_dst   = (r_opcode == OP_RTYPE);
                o_reg_src   = (r_opcode == OP_LW) ? REG_SRC_MEM : REG_SRC_ALU;
                w_retire    = 1'b1;
            end
            S_SYS: begin
                o_syscall = 1'b1;
                if (i_sys_ack) w_retire = 1'b1;
            end
            S_HALT, S_FAULT: begin
            end
            default: w_state_next = S_IDLE;
        endcase

        // The retiring cycle is also the instruction boundary where run is sampled.
        if (w_retire) w_state_next = i_run ? S_FETCH : S_IDLE;
    end

    assign w_active = (r_state != S_IDLE) && (r_state != S_HALT) && (r_state != S_FAULT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_opcode     <= OP_RTYPE;
            r_func       <= '0;
            r_fault_code <= FAULT_NONE;
            r_cycle_cnt  <= '0;
            r_instr_cnt  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_fault_code <= w_fault_code_next;
            if (r_state == S_DECODE) begin
                r_opcode <= i_opcode;
                r_func   <= i_func;
            end
            if (w_active) r_cycle_cnt <= r_cycle_cnt + 1'b1;
            if (w_retire) r_instr_cnt <= r_instr_cnt + 1'b1;
        end
    end

    assign o_halt       = (r_state == S_HALT);
    assign o_fault      = (r_state == S_FAULT);
    assign o_fault_code = r_fault_code;
    assign o_cycle_cnt  = r_cycle_cnt;
    assign o_instr_cnt  = r_instr_cnt;

endmodule

// File: tb/tb_multicycle_cpu_ctrl.sv
// Directed bench for multicycle_cpu_ctrl: per-cycle strobe vectors and counter/flag
// checkpoints, all hand-computed, with TIMEOUT=4 to exercise the memory watchdog.
module tb_multicycle_cpu_ctrl;

    localparam int CNT_W = 32;

    // Strobe word: {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, npc_sel[1:0],
    //               reg_write, reg_dst, reg_src[1:0], alu_src2, alu_op[1:0], syscall}
    localparam logic [14:0] ST_NONE     = 15'h0000;
    localparam logic [14:0] ST_F_WAIT   = 15'h4000;
    localparam logic [14:0] ST_F_ACC    = 15'h4C00;
    localparam logic [14:0] ST_D_J      = 15'h0600;
    localparam logic [14:0] ST_E_R      = 15'h0004;
    localparam logic [14:0] ST_E_IMM    = 15'h0008;
    localparam logic [14:0] ST_E_BEQ_T  = 15'h0502;
    localparam logic [14:0] ST_E_BEQ_N  = 15'h0102;
    localparam logic [14:0] ST_M_LW     = 15'h5000;
    localparam logic [14:0] ST_M_SW     = 15'h7000;
    localparam logic [14:0] ST_W_R      = 15'h00C0;
    localparam logic [14:0] ST_W_ADDI   = 15'h0080;
    localparam logic [14:0] ST_W_LW     = 15'h0090;
    localparam logic [14:0] ST_SYS      = 15'h0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             i_rst, i_run, i_zero, i_mem_ready, i_sys_ack;
    logic [5:0]       i_opcode, i_func;
    logic             o_mem_req, o_mem_we, o_mem_addr_sel, o_ir_write, o_pc_write;
    logic [1:0]       o_npc_sel, o_reg_src, o_alu_op, o_fault_code;
    logic             o_reg_write, o_reg_dst, o_alu_src2, o_syscall, o_halt, o_fault;
    logic [CNT_W-1:0] o_cycle_cnt, o_instr_cnt;
    logic [14:0]      w_strb;

    multicycle_cpu_ctrl #(.TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_run          (i_run),
        .i_opcode       (i_opcode),
        .i_func         (i_func),
        .i_zero         (i_zero),
        .i_mem_ready    (i_mem_ready),
        .i_sys_ack      (i_sys_ack),
        .o_mem_req      (o_mem_req),
        .o_mem_we       (o_mem_we),
        .o_mem_addr_sel (o_mem_addr_sel),
        .o_ir_write     (o_ir_write),
        .o_pc_write     (o_pc_write),
        .o_npc_sel      (o_npc_sel),
        .o_reg_write    (o_reg_write),
        .o_reg_dst      (o_reg_dst),
        .o_reg_src      (o_reg_src),
        .o_alu_src2     (o_alu_src2),
        .o_alu_op       (o_alu_op),
        .o_syscall      (o_syscall),
        .o_halt         (o_halt),
        .o_fault        (o_fault),
        .o_fault_code   (o_fault_code),
        .o_cycle_cnt    (o_cycle_cnt),
        .o_instr_cnt    (o_instr_cnt)
    );

    assign w_strb = {o_mem_req, o_mem_we, o_mem_addr_sel, o_ir_write, o_pc_write, o_npc_sel,
                     o_reg_write, o_reg_dst, o_reg_src, o_alu_src2, o_alu_op, o_syscall};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check strobes mid-cycle, advance to just past the next edge.
    task automatic cyc(input string tag, input logic [14:0] exp, input logic run,
                       input logic rdy, input logic zero, input logic ack);
        i_run       = run;
        i_mem_ready = rdy;
        i_zero      = zero;
        i_sys_ack   = ack;
        #1;
        check(tag, 32'(w_strb), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic status(input string tag, input logic [31:0] exp_cyc, input logic [31:0] exp_ins,
                          input logic exp_halt, input logic exp_fault, input logic [1:0] exp_code);
        check({tag, "_cycle_cnt"}, o_cycle_cnt, exp_cyc);
        check({tag, "_instr_cnt"}, o_instr_cnt, exp_ins);
        check({tag, "_halt"}, 32'(o_halt), 32'(exp_halt));
        check({tag, "_fault"}, 32'(o_fault), 32'(exp_fault));
        check({tag, "_fault_code"}, 32'(o_fault_code), 32'(exp_code));
        $display("txn %s: cycle_cnt=%0d instr_cnt=%0d halt=%0b fault=%0b code=%0d",
                 tag, o_cycle_cnt, o_instr_cnt, o_halt, o_fault, o_fault_code);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_run = 1'b0;
        @(posedge clk);
        #1;
        i_rst = 1'b0;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
        i_opcode = op;
        i_func   = fn;
    endtask

    initial begin
        i_rst = 1'b1; i_run = 1'b0; i_opcode = 6'h00; i_func = 6'h00;
        i_zero = 1'b0; i_mem_ready = 1'b0; i_sys_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        i_rst = 1'b0;
        #1;
        check("reset_strobes", 32'(w_strb), 32'(ST_NONE));
        status("reset", 0, 0, 1'b0, 1'b0, 2'b00);
        cyc("idle_run0", ST_NONE, 1'b0, 1'b1, 1'b0, 1'b0);
        check("idle_run0_cycle_cnt", o_cycle_cnt, 0);

        // add, zero-wait: F D E W
        set_instr(6'h00, 6'h20);
        cyc("add_idle", ST_NONE,  1'b1, 1'b1, 1'b0, 1'b0);
        cyc("add_F",    ST_F_ACC, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("add_D",    ST_NONE,  1'b1, 1'b1, 1'b0, 1'b0);
        cyc("add_E",    ST_E_R,   1'b1, 1'b1, 1'b0, 1'b0);
        cyc("add_W",    ST_W_R,   1'b1, 1'b1, 1'b0, 1'b0);
        status("add", 4, 1, 1'b0, 1'b0, 2'b00);

        // lw with three memory wait cycles: 8 cycles total
        set_instr(6'h23, 6'h00);
        cyc("lw_F", ST_F_ACC, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("lw_D", ST_NONE,  1'b1, 1'b1, 1'b0, 1'b0);
        cyc("lw_E", ST_E_IMM, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("lw_M_wait", ST_M_LW, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("lw_M_rdy", ST_M_LW, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("lw_W",     ST_W_LW, 1'b1, 1'b1, 1'b0, 1'b0);
        status("lw", 12, 2, 1'b0, 1'b0, 2'b00);

        // beq taken, then not taken
        set_instr(6'h04, 6'h00);
        cyc("beqT_F", ST_F_ACC,   1'b1, 1'b1, 1'b0, 1'b0);
        cyc("beqT_D", ST_NONE,    1'b1, 1'b1, 1'b0, 1'b0);
        cyc("beqT_E", ST_E_BEQ_T, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("beqN_F", ST_F_ACC,   1'b1, 1'b1, 1'b0, 1'b0);
        cyc("beqN_D", ST_NONE,    1'b1, 1'b1, 1'b0, 1'b0);
        cyc("beqN_E", ST_E_BEQ_N, 1'b1, 1'b1, 1'b0, 1'b0);
        status("beq", 18, 4, 1'b0, 1'b0, 2'b00);

        // sw retires in MEM
        set_instr(6'h2B, 6'h00);
        cyc("sw_F", ST_F_ACC, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("sw_D", ST_NONE,  1'b1, 1'b1, 1'b0, 1'b0);
        cyc("sw_E", ST_E_IMM, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("sw_M", ST_M_SW,  1'b1, 1'b1, 1'b0, 1'b0);
        status("sw", 22, 5, 1'b0, 1'b0, 2'b00);

        // addi whose fetch is ready exactly on the TIMEOUT-th cycle: no fault
        set_instr(6'h08, 6'h00);
        for (int i = 0; i < 3; i++) cyc("addi_F_wait", ST_F_WAIT, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("addi_F_rdy4", ST_F_ACC,  1'b1, 1'b1, 1'b0, 1'b0);
        cyc("addi_D",      ST_NONE,   1'b1, 1'b1, 1'b0, 1'b0);
        cyc("addi_E",      ST_E_IMM,  1'b1, 1'b1, 1'b0, 1'b0);
        cyc("addi_W",      ST_W_ADDI, 1'b1, 1'b1, 1'b0, 1'b0);
        status("addi", 29, 6, 1'b0, 1'b0, 2'b00);

        // j retires in DECODE
        set_instr(6'h02, 6'h00);
        cyc("j_F", ST_F_ACC, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("j_D", ST_D_J,   1'b1, 1'b1, 1'b0, 1'b0);
        status("j", 31, 7, 1'b0, 1'b0, 2'b00);

        // syscall, ack on the fifth SYS cycle
        set_instr(6'h00, 6'h0C);
        cyc("sys_F", ST_F_ACC, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("sys_D", ST_NONE,  1'b1, 1'b1, 1'b0, 1'b0);
        cyc("sys_E", ST_E_R,   1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc("sys_wait", ST_SYS, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("sys_ack", ST_SYS, 1'b1, 1'b1, 1'b0, 1'b1);
        status("syscall", 39, 8, 1'b0, 1'b0, 2'b00);

        // halt: sticky, counters frozen, inputs ignored
        set_instr(6'h3F, 6'h00);
        cyc("halt_F", ST_F_ACC, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("halt_D", ST_NONE,  1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("halt_hold", ST_NONE, 1'b1, 1'b1, 1'b1, 1'b1);
        status("halt", 41, 8, 1'b1, 1'b0, 2'b00);

        // reset during a MEM wait
        do_reset();
        status("rst1", 0, 0, 1'b0, 1'b0, 2'b00);
        set_instr(6'h23, 6'h00);
        cyc("lw2_idle", ST_NONE,  1'b1, 1'b1, 1'b0, 1'b0);
        cyc("lw2_F",    ST_F_ACC, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("lw2_D",    ST_NONE,  1'b1, 1'b1, 1'b0, 1'b0);
        cyc("lw2_E",    ST_E_IMM, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("lw2_M_wait", ST_M_LW, 1'b1, 1'b0, 1'b0, 1'b0);
        i_rst = 1'b1;
        cyc("lw2_M_rst", ST_M_LW, 1'b1, 1'b0, 1'b0, 1'b0);
        i_rst = 1'b0;
        status("mid_mem_rst", 0, 0, 1'b0, 1'b0, 2'b00);
        cyc("idle_after_rst", ST_NONE, 1'b0, 1'b1, 1'b0, 1'b0);
        check("idle_after_rst_cycle_cnt", o_cycle_cnt, 0);

        // run=0 at retire returns to IDLE
        set_instr(6'h02, 6'h00);
        cyc("j2_idle", ST_NONE,  1'b1, 1'b1, 1'b0, 1'b0);
        cyc("j2_F",    ST_F_ACC, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("j2_D",    ST_D_J,   1'b0, 1'b1, 1'b0, 1'b0);
        cyc("j2_back_idle", ST_NONE, 1'b0, 1'b1, 1'b0, 1'b0);
        status("run0_retire", 2, 1, 1'b0, 1'b0, 2'b00);

        // fetch never ready: fault after 4 wait cycles
        cyc("tmo_idle", ST_NONE, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc("tmo_F_wait", ST_F_WAIT, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cyc("tmo_flt_hold", ST_NONE, 1'b1, 1'b1, 1'b1, 1'b1);
        status("mem_timeout", 6, 1, 1'b0, 1'b1, 2'b01);

        // illegal opcode
        do_reset();
        set_instr(6'h3E, 6'h00);
        cyc("ill_idle", ST_NONE,  1'b1, 1'b1, 1'b0, 1'b0);
        cyc("ill_F",    ST_F_ACC, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("ill_D",    ST_NONE,  1'b1, 1'b1, 1'b0, 1'b0);
        cyc("ill_hold", ST_NONE,  1'b1, 1'b1, 1'b0, 1'b0);
        status("illegal", 2, 0, 1'b0, 1'b1, 2'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
